// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
//
// Run/stop and configuration controller around a programmable half-period
// clock divider. The divider counts cnt down from the active reload H; each
// time cnt reaches zero, clk_out toggles and cnt reloads, so every half-period
// lasts H+1 cycles. New divide values offered while running are held in a
// shadow register and only applied at a reload, so no phase is ever cut short.
// A non-zero burst value emits exactly that many full periods and then parks
// clk_out low.
//
// Optional feature (macro CLK_DIV_CTRL_OVERRUN_EN): adds the sticky cfg_overrun
// output, set by an offer made while cfg_ready is low.
//
// Ports:
//   clk_50mhz   in   system clock
//   reset       in   asynchronous active-high reset
//   start       in   one-cycle request to begin output (honoured in IDLE only)
//   stop        in   one-cycle request to end output
//   cfg_valid   in   configuration offer
//   cfg_ready   out  configuration acceptance (transfer = cfg_valid & cfg_ready)
//   cfg_half    in   reload value H, half-period = H+1 cycles
//   cfg_burst   in   number of full periods to emit, 0 = continuous
//   clk_out     out  divided clock, registered
//   tick        out  one-cycle pulse in the cycle clk_out rises
//   busy        out  high while in RUN or STOPPING
//   done        out  one-cycle pulse when the output parks low
//   cfg_overrun out  sticky rejected-offer flag (only with the macro)
//   dbg_state   out  current FSM state, for observation
//
// Handshake: a configuration word moves on every rising clock edge where
// cfg_valid and cfg_ready are both high; cfg_ready does not depend on
// cfg_valid, and an offer seen while cfg_ready is low is simply not taken.
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int CNT_W        = 25,
    parameter int DEFAULT_HALF = 24999999,
    parameter int BURST_W      = 8
) (
    input  logic               clk_50mhz,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_half,
    input  logic [BURST_W-1:0] cfg_burst,
    output logic               clk_out,
    output logic               tick,
    output logic               busy,
    output logic               done,
`ifdef CLK_DIV_CTRL_OVERRUN_EN
    output logic               cfg_overrun,
`endif
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEFAULT_HALF);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   half_act_q;
    logic [BURST_W-1:0] burst_act_q;
    logic [CNT_W-1:0]   shadow_half_q;
    logic [BURST_W-1:0] shadow_burst_q;
    logic               pending_q;
    logic [BURST_W-1:0] per_cnt_q;
    logic               clk_out_q;
    logic               tick_q;
    logic               busy_q;
    logic               done_q;

    logic               xfer;
    logic               active;
    logic               cnt_zero;
    logic               rising;
    logic               falling;
    logic               burst_hit;
    logic               go_idle;
    logic               rise_tick;
    logic               start_acc;
    logic [CNT_W-1:0]   reload_half_d;

    // pending only ever gets set outside IDLE, so this is also 1 in IDLE
    assign cfg_ready = !pending_q;
    assign xfer      = cfg_valid && cfg_ready;
    assign active    = (state_q != ST_IDLE);
    assign cnt_zero  = (cnt_q == '0);
    assign rising    = active && cnt_zero && !clk_out_q;
    assign falling   = active && cnt_zero && clk_out_q;
    assign burst_hit = (burst_act_q != '0) && (per_cnt_q == burst_act_q);
    assign start_acc = (state_q == ST_IDLE) && start && !stop;

    // A pending shadow takes effect at the very reload that consumes it.
    assign reload_half_d = pending_q ? shadow_half_q : half_act_q;

    // Leaving the active states: either a stop that lands on a low phase that
    // has just expired (toggle suppressed), or any falling toggle that ends a
    // stop request or a completed burst. Stopping on a high phase always waits
    // for the falling toggle, so the last high phase keeps its full length.
    assign go_idle = (rising && stop && (state_q == ST_RUN)) ||
                     (falling && (stop || (state_q == ST_STOPPING) || burst_hit));

    // Ticks only come from RUN; rising toggles inside STOPPING are silent.
    assign rise_tick = rising && (state_q == ST_RUN) && !stop;

    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= DEF_HALF;
            half_act_q     <= DEF_HALF;
            burst_act_q    <= '0;
            shadow_half_q  <= '0;
            shadow_burst_q <= '0;
            pending_q      <= 1'b0;
            per_cnt_q      <= '0;
            clk_out_q      <= 1'b0;
            tick_q         <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    clk_out_q <= 1'b0;
                    cnt_q     <= half_act_q;
                    if (xfer) begin
                        half_act_q  <= cfg_half;
                        burst_act_q <= cfg_burst;
                        cnt_q       <= cfg_half;
                    end
                    if (start_acc) begin
                        state_q   <= ST_RUN;
                        per_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end

                ST_RUN, ST_STOPPING: begin
                    if (cnt_zero) begin
                        cnt_q     <= reload_half_d;
                        clk_out_q <= go_idle ? 1'b0 : !clk_out_q;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end

                    if (rise_tick) begin
                        tick_q    <= 1'b1;
                        per_cnt_q <= per_cnt_q + BURST_W'(1);
                    end

                    if (cnt_zero && pending_q) begin
                        half_act_q  <= shadow_half_q;
                        burst_act_q <= shadow_burst_q;
                        pending_q   <= 1'b0;
                        // A rising toggle at the apply point is the first
                        // period of the new burst, so it counts as one.
                        per_cnt_q   <= rise_tick ? BURST_W'(1) : '0;
                    end

                    if (go_idle) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        // No later reload exists, so an offer taken on the
                        // way out goes straight to the active registers.
                        if (xfer) begin
                            half_act_q  <= cfg_half;
                            burst_act_q <= cfg_burst;
                            cnt_q       <= cfg_half;
                        end
                    end else begin
                        if (stop && (state_q == ST_RUN)) begin
                            state_q <= ST_STOPPING;
                        end
                        if (xfer) begin
                            shadow_half_q  <= cfg_half;
                            shadow_burst_q <= cfg_burst;
                            pending_q      <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    clk_out_q <= 1'b0;
                    busy_q    <= 1'b0;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLK_DIV_CTRL_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk_50mhz or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (cfg_valid && !cfg_ready) begin
            overrun_q <= 1'b1;
        end else if (start_acc) begin
            overrun_q <= 1'b0;
        end
    end

    assign cfg_overrun = overrun_q;
`endif

    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Run/stop and configuration controller wrapped around a programmable half-period clock divider in the 50 MHz domain.
- Sequences the divider through idle, running and stopping phases, and applies new divide values only at safe reload points, so the output never glitches.
- Optionally emits a burst of N full periods and then parks low.
- Feeds the slow-clock and tick consumers in the lab designs (display scan, seconds counters).

Parameters:
- CNT_W, 25, width of the half-period counter and of the cfg_half field.
- DEFAULT_HALF, 24999999, reset value of the active half-period reload (1 Hz output at 50 MHz).
- BURST_W, 8, width of the burst period counter.

Ports:
- clk_50mhz  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin output.
- stop  input  1  one-cycle request to end output.
- cfg_valid  input  1  configuration offer.
- cfg_ready  output  1  configuration acceptance; a transfer occurs when cfg_valid and cfg_ready are both high.
- cfg_half  input  CNT_W  reload value H; half-period = H+1 cycles.
- cfg_burst  input  BURST_W  number of full periods to emit; 0 means continuous.
- clk_out  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse in the cycle clk_out goes 0->1.
- busy  output  1  high in RUN and STOPPING.
- done  output  1  one-cycle pulse when output parks after stop or burst end.

Behaviour:
- Reset (async, active-high): state=IDLE, cnt=DEFAULT_HALF, half_act=DEFAULT_HALF, burst_act=0, no pending config.
  - Output reset values: clk_out=0, tick=0, busy=0, done=0, cfg_ready=1.
  - Reset mid-operation aborts immediately; clk_out goes to 0 asynchronously.
- States: IDLE, RUN, STOPPING.
- IDLE:
  - clk_out=0, cnt held at half_act.
  - A cfg transfer writes half_act/burst_act directly and loads cnt.
  - start -> RUN, with cnt=half_act and period counter=0.
  - start and stop in the same cycle: stop wins, stay IDLE, no done pulse.
  - start and cfg transfer in the same cycle: the new config is used for the first period.
- RUN:
  - cnt decrements each cycle.
  - When cnt==0: toggle clk_out and reload cnt from half_act (or from the pending shadow, see Config).
  - On a 0->1 toggle: tick=1 and the period counter increments (modulo 2^BURST_W).
  - Burst end: if burst_act!=0 and the period counter has reached burst_act, the next 1->0 toggle -> IDLE with done=1 in that cycle.
  - stop -> STOPPING. If clk_out is already 0 and cnt==0 in that same cycle, suppress the toggle, go directly to IDLE, done=1.
- STOPPING:
  - Counting continues; at the next toggle that drives clk_out to 0 -> IDLE, done=1.
  - No further tick is generated.
  - A start in STOPPING is ignored.
  - The last high phase always has full length.
- Config:
  - cfg_ready=1 in IDLE, or in RUN/STOPPING while no shadow config is pending.
  - A transfer in RUN/STOPPING latches the shadow registers and sets pending, which forces cfg_ready=0.
  - At the next reload, half_act/burst_act take the shadow values and pending clears; that reload already uses the new H.
  - A transfer in the same cycle as a reload is applied at the following reload, not the current one.
  - The period counter is cleared when a new burst_act is applied.
- Arithmetic:
  - cnt is CNT_W bits, unsigned.
  - H=0 gives a toggle every cycle (clk_out = clk_50mhz/2).
  - H = 2^CNT_W-1 is legal; there is no clamping.
- busy = (state != IDLE), registered.
- done and tick are never high in the same cycle.

Optional Feature:
- Macro: CLK_DIV_CTRL_OVERRUN_EN.
- Defined:
  - Adds output cfg_overrun (1 bit), a sticky flag set when cfg_valid=1 while cfg_ready=0.
  - Cleared by reset or by an accepted start; reset value 0.
  - The rejected offer is not latched.
- Not defined: the port and its logic are absent; offers against cfg_ready=0 are simply not transferred.

Test Plan:
- Reset, then start with default H=24999999 -> first 0->1 edge after 25000000 cycles; tick pulses every 50000000 cycles; busy=1.
- IDLE cfg H=3, burst=0, then start -> clk_out high 4 / low 4 cycles repeating; tick every 8 cycles; cfg_ready stays 1.
- H=3, burst=2, start -> exactly 2 full periods (16 cycles), done=1 on the final falling edge, busy=0 next cycle, clk_out stays 0.
- Running H=3, cfg H=1 offered mid high phase -> cfg_ready drops until the next reload; the following phase lasts 2 cycles; a second offer while pending is not transferred (and sets cfg_overrun=1 when CLK_DIV_CTRL_OVERRUN_EN is defined).
- stop asserted 1 cycle into a high phase, H=3 -> high phase completes its 4 cycles, clk_out falls, done=1, no extra tick; start with stop in IDLE -> no output.
- Assert reset while clk_out=1 in RUN -> clk_out=0 and busy=0 immediately; cnt=DEFAULT_HALF and cfg_ready=1 after release.
